puf_eval_ctrl: RTL and testbench
================================

Name: puf_eval_ctrl

Overview:
- Sequencer placed directly upstream of the 16-bit XOR-arbiter PUF array.
- Accepts a challenge over a valid/ready handshake and drives the array's challenge bus and launch pulse.
- Samples the array's response NVOTE times and returns the per-bit majority word over a valid/ready handshake.
- Temporal majority voting suppresses metastable or marginal arbiter bits before the response reaches key or ID logic.

Parameters:
- CW, 16, challenge width (matches PUF array challenge bus)
- RW, 16, response width (matches PUF array response bus)
- PULSE_CYCLES, 2, cycles puf_pulse held high per evaluation; must be >=1
- SETTLE_CYCLES, 4, cycles puf_pulse held low before sampling; must be >=2 (covers synchronizer)
- NVOTE, 5, evaluations per request; must be odd and >=1

Ports:
- clk  input  1  single clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  challenge request valid
- req_ready  output  1  block idle, can accept a request
- req_challenge  input  CW  challenge to evaluate
- puf_challenge  output  CW  registered challenge to the PUF array
- puf_pulse  output  1  launch pulse to the PUF array
- puf_response  input  RW  raw (asynchronous) PUF array response
- rsp_valid  output  1  voted response available
- rsp_ready  input  1  consumer accepts response
- rsp_data  output  RW  majority-voted response

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, puf_challenge=0, puf_pulse=0, rsp_valid=0, rsp_data=0
  - vote counters=0, round counter=0, synchronizer flops=0, req_ready=1 on the next cycle
  - Applies from any state, including mid-evaluation; the in-flight request is discarded with no response.
- puf_response passes through a 2-flop synchronizer (all RW bits). The SAMPLE state reads the second flop.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch req_challenge into puf_challenge, clear vote and round counters, go to LAUNCH.
- LAUNCH: puf_pulse=1 for exactly PULSE_CYCLES cycles, then go to SETTLE.
- SETTLE: puf_pulse=0 for exactly SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE (1 cycle):
  - For each bit i, vote_cnt[i] += sync_resp[i]. Round counter increments.
  - If round count now equals NVOTE, go to DONE; otherwise go to LAUNCH.
- DONE:
  - rsp_valid=1; rsp_data[i] = (vote_cnt[i] > NVOTE/2), registered on entry.
  - Output is held stable until rsp_ready=1, then go to IDLE.
  - A new request is never accepted in the same cycle as the response handshake.
- req_ready=0 in every state except IDLE.
- puf_challenge stays constant from acceptance until the next acceptance.
- Vote counters are $clog2(NVOTE+1) bits wide; they cannot overflow (at most NVOTE increments).
- Latency: rsp_valid rises NVOTE*(PULSE_CYCLES+SETTLE_CYCLES+1)+1 cycles after the accepting edge (defaults: 36).
- NVOTE=1: single evaluation; rsp_data equals the synchronized sample.
- Illegal parameters (even NVOTE, SETTLE_CYCLES<2, PULSE_CYCLES<1) are flagged by an elaboration-time check.

Optional Feature:
- Macro PUF_STABILITY_MASK_EN.
- When defined:
  - Adds output rsp_stable [RW]. Bit i=1 iff vote_cnt[i] is 0 or NVOTE (unanimous).
  - Valid and held with rsp_data; reset value 0.
- When undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package puf_pkg holds:
  - state enum (IDLE, LAUNCH, SETTLE, SAMPLE, DONE)
  - default widths PUF_CW=16, PUF_RW=16
  - vote-counter width function
- One natural sub-module: puf_vote_acc, the RW-wide per-bit vote counter bank with clear/accumulate/majority/unanimity outputs.
- Synchronizer and FSM live in puf_eval_ctrl.

Test Plan:
- Reset then idle: after rst, req_ready=1, rsp_valid=0, puf_pulse=0, puf_challenge=0.
- Stable model, response = challenge^16'hA5A5: req_challenge=16'h1234 → puf_pulse high 2 cycles per round, 5 rounds; rsp_data=16'hB791 exactly 36 cycles after the accept edge.
- Noisy model flips bit 0 in 2 of 5 rounds, base response 16'h0001 → rsp_data=16'h0001. With PUF_STABILITY_MASK_EN, rsp_stable=16'hFFFE.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid → rsp_data stable, req_ready=0, puf_pulse=0 throughout. Raising rsp_ready returns to IDLE next cycle.
- Reset mid-op: rst asserted during round 3 SETTLE → next cycle state IDLE, rsp_valid never rises. A following request 16'h00FF completes normally with full 36-cycle latency.
- Back-to-back requests: req_valid held high with two challenges → second accepted only after the first response handshake, no overlap; puf_challenge switches on the second accept.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared types and defaults for the PUF evaluation sequencer and its vote bank.
package puf_pkg;

  localparam int unsigned PUF_CW = 16;
  localparam int unsigned PUF_RW = 16;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    SETTLE,
    SAMPLE,
    DONE
  } puf_state_e;

  // Counter width able to hold values 0..n inclusive.
  function automatic int unsigned vote_cnt_w(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/puf_vote_acc.sv
// Per-bit temporal vote counter bank with majority and (optional) unanimity decode.
// Unanimity output exists only when PUF_STABILITY_MASK_EN is defined.
module puf_vote_acc
  import puf_pkg::*;
#(
  parameter int unsigned RW    = PUF_RW,
  parameter int unsigned NVOTE = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          acc,
  input  logic [RW-1:0] din,
  output logic [RW-1:0] maj
`ifdef PUF_STABILITY_MASK_EN
  ,
  output logic [RW-1:0] unan
`endif
);

  localparam int unsigned VW = vote_cnt_w(NVOTE);

  logic [VW-1:0] cnt [RW];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int unsigned i = 0; i < RW; i++) cnt[i] <= '0;
    end else if (acc) begin
      for (int unsigned i = 0; i < RW; i++) cnt[i] <= cnt[i] + VW'(din[i]);
    end
  end

  always_comb begin
    maj = '0;
    for (int unsigned i = 0; i < RW; i++) maj[i] = (cnt[i] > VW'(NVOTE / 2));
  end

`ifdef PUF_STABILITY_MASK_EN
  always_comb begin
    unan = '0;
    for (int unsigned i = 0; i < RW; i++)
      unan[i] = (cnt[i] == '0) || (cnt[i] == VW'(NVOTE));
  end
`endif

endmodule

// File: rtl/puf_eval_ctrl.sv
// Challenge sequencer for the XOR-arbiter PUF array with NVOTE-round majority voting.
// Optional rsp_stable unanimity mask enabled by PUF_STABILITY_MASK_EN.
module puf_eval_ctrl
  import puf_pkg::*;
#(
  parameter int unsigned CW            = PUF_CW,
  parameter int unsigned RW            = PUF_RW,
  parameter int unsigned PULSE_CYCLES  = 2,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned NVOTE         = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [CW-1:0] req_challenge,
  output logic [CW-1:0] puf_challenge,
  output logic          puf_pulse,
  input  logic [RW-1:0] puf_response,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [RW-1:0] rsp_data
`ifdef PUF_STABILITY_MASK_EN
  ,
  output logic [RW-1:0] rsp_stable
`endif
);

  if ((NVOTE % 2) == 0 || NVOTE < 1) begin : g_bad_nvote
    $error("puf_eval_ctrl: NVOTE must be odd and >= 1");
  end
  if (SETTLE_CYCLES < 2) begin : g_bad_settle
    $error("puf_eval_ctrl: SETTLE_CYCLES must be >= 2");
  end
  if (PULSE_CYCLES < 1) begin : g_bad_pulse
    $error("puf_eval_ctrl: PULSE_CYCLES must be >= 1");
  end

  localparam int unsigned PMAX = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned PW   = vote_cnt_w(PMAX);
  localparam int unsigned RCW  = vote_cnt_w(NVOTE);

  puf_state_e     state, state_n;
  logic [PW-1:0]  cnt;
  logic [RCW-1:0] rnd;
  logic [RW-1:0]  sync1, sync2;
  logic [RW-1:0]  maj;
  logic           accept, acc_en, capture, pulse_n;
`ifdef PUF_STABILITY_MASK_EN
  logic [RW-1:0]  unan;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (req_valid) state_n = LAUNCH;
      LAUNCH:  if (cnt == PW'(PULSE_CYCLES - 1)) state_n = SETTLE;
      SETTLE:  if (cnt == PW'(SETTLE_CYCLES - 1)) state_n = SAMPLE;
      SAMPLE:  state_n = (rnd == RCW'(NVOTE - 1)) ? DONE : LAUNCH;
      DONE:    if (rsp_valid && rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // rsp_valid only asserts on the second DONE cycle, once the last sample has
  // landed in the counters, so the first DONE cycle ignores rsp_ready.
  always_comb begin
    req_ready = (state == IDLE);
    accept    = (state == IDLE) && req_valid;
    acc_en    = (state == SAMPLE);
    capture   = (state == DONE) && !rsp_valid;
    pulse_n   = (state_n == LAUNCH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1         <= '0;
      sync2         <= '0;
      cnt           <= '0;
      rnd           <= '0;
      puf_challenge <= '0;
      puf_pulse     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
`ifdef PUF_STABILITY_MASK_EN
      rsp_stable    <= '0;
`endif
    end else begin
      sync1     <= puf_response;
      sync2     <= sync1;
      puf_pulse <= pulse_n;

      if ((state == LAUNCH || state == SETTLE) && state_n == state) cnt <= cnt + PW'(1);
      else                                                          cnt <= '0;

      if (accept) begin
        puf_challenge <= req_challenge;
        rnd           <= '0;
      end else if (acc_en) begin
        rnd <= rnd + RCW'(1);
      end

      if (capture) begin
        rsp_valid  <= 1'b1;
        rsp_data   <= maj;
`ifdef PUF_STABILITY_MASK_EN
        rsp_stable <= unan;
`endif
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  puf_vote_acc #(
    .RW    (RW),
    .NVOTE (NVOTE)
  ) u_vote (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .acc  (acc_en),
    .din  (sync2),
    .maj  (maj)
`ifdef PUF_STABILITY_MASK_EN
    ,
    .unan (unan)
`endif
  );

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Directed bench for puf_eval_ctrl: behavioural PUF model plus expected-response queue.
// Checks rsp_stable too when PUF_STABILITY_MASK_EN is defined.
module tb_puf_eval_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_challenge;
  logic [15:0] puf_challenge;
  logic        puf_pulse;
  logic [15:0] puf_response = '0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
`ifdef PUF_STABILITY_MASK_EN
  logic [15:0] rsp_stable;
`endif

  typedef struct packed {
    logic [15:0] data;
    logic [15:0] stab;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int   n_cmp = 0;
  int   n_err = 0;
  int   pulse_total = 0;
  int   base = 0;
  bit   noisy = 1'b0;

  always #5 clk = ~clk;

  puf_eval_ctrl #(
    .CW            (16),
    .RW            (16),
    .PULSE_CYCLES  (2),
    .SETTLE_CYCLES (4),
    .NVOTE         (5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_challenge (req_challenge),
    .puf_challenge (puf_challenge),
    .puf_pulse     (puf_pulse),
    .puf_response  (puf_response),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data)
`ifdef PUF_STABILITY_MASK_EN
    ,
    .rsp_stable    (rsp_stable)
`endif
  );

  // PUF array model: stable = challenge ^ A5A5; noisy = 0001 with bit 0 flipped in rounds 1 and 2.
  always @(posedge puf_pulse) begin
    int idx;
    pulse_total++;
    idx = pulse_total - base;
    #1;
    if (noisy) puf_response = 16'h0001 ^ ((idx == 1 || idx == 2) ? 16'h0001 : 16'h0000);
    else       puf_response = puf_challenge ^ 16'hA5A5;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] c, input exp_t e);
    req_challenge = c;
    req_valid     = 1'b1;
    sb.push_back(e);
    base = pulse_total;
    tick();
    req_valid = 1'b0;
    chk("accept_challenge", puf_challenge, c);
    chk("accept_busy", req_ready, 0);
  endtask

  // Called at the sample just after the accepting edge; returns at the first rsp_valid sample.
  task automatic wait_rsp(input string tag);
    int   k, hi, rises;
    logic prev;
    exp_t e;
    k     = 0;
    hi    = puf_pulse ? 1 : 0;
    rises = hi;
    prev  = puf_pulse;
    while (!rsp_valid && k < 200) begin
      tick();
      k++;
      if (puf_pulse) hi++;
      if (puf_pulse && !prev) rises++;
      prev = puf_pulse;
    end
    chk({tag, "_latency"}, k, 36);
    chk({tag, "_pulse_cycles"}, hi, 10);
    chk({tag, "_rounds"}, rises, 5);
    chk({tag, "_sb_nonempty"}, (sb.size() > 0) ? 1 : 0, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      last_exp = e;
      chk({tag, "_data"}, rsp_data, e.data);
`ifdef PUF_STABILITY_MASK_EN
      chk({tag, "_stable"}, rsp_stable, e.stab);
`endif
    end
  endtask

  initial begin
    int vhi;
    rst           = 1'b1;
    req_valid     = 1'b0;
    req_challenge = '0;
    rsp_ready     = 1'b1;
    tick(); tick(); tick();

    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_pulse", puf_pulse, 0);
    chk("rst_challenge", puf_challenge, 16'h0000);
    chk("rst_rsp_data", rsp_data, 16'h0000);
    rst = 1'b0;
    tick();
    chk("idle_req_ready", req_ready, 1);

    // Stable model
    issue(16'h1234, '{data: 16'hB791, stab: 16'hFFFF});
    wait_rsp("stable");
    chk("stable_busy_in_done", req_ready, 0);
    tick();
    chk("stable_hs_valid", rsp_valid, 0);
    chk("stable_hs_idle", req_ready, 1);

    // Noisy model under backpressure
    noisy     = 1'b1;
    rsp_ready = 1'b0;
    issue(16'h0000, '{data: 16'h0001, stab: 16'hFFFE});
    wait_rsp("noisy");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, last_exp.data);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_pulse", puf_pulse, 0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_release_valid", rsp_valid, 0);
    chk("bp_release_idle", req_ready, 1);
    noisy = 1'b0;

    // Reset during round 3 SETTLE
    issue(16'h1234, '{data: 16'hB791, stab: 16'hFFFF});
    for (int i = 0; i < 18; i++) tick();
    chk("midrst_in_settle", puf_pulse, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    chk("midrst_idle", req_ready, 1);
    chk("midrst_valid", rsp_valid, 0);
    chk("midrst_pulse", puf_pulse, 0);
    chk("midrst_challenge", puf_challenge, 16'h0000);
    vhi = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rsp_valid) vhi++;
    end
    chk("midrst_no_rsp", vhi, 0);
    issue(16'h00FF, '{data: 16'hA55A, stab: 16'hFFFF});
    wait_rsp("after_rst");
    tick();
    chk("after_rst_hs", rsp_valid, 0);

    // Back-to-back with req_valid held high
    req_challenge = 16'h0F0F;
    req_valid     = 1'b1;
    sb.push_back('{data: 16'hAAAA, stab: 16'hFFFF});
    base = pulse_total;
    tick();
    req_challenge = 16'hC3C3;
    chk("b2b_first_challenge", puf_challenge, 16'h0F0F);
    wait_rsp("b2b_first");
    chk("b2b_no_accept_in_done", req_ready, 0);
    chk("b2b_hold_challenge", puf_challenge, 16'h0F0F);
    tick();
    chk("b2b_hs_valid", rsp_valid, 0);
    chk("b2b_hs_idle", req_ready, 1);
    chk("b2b_hs_challenge", puf_challenge, 16'h0F0F);
    sb.push_back('{data: 16'h6666, stab: 16'hFFFF});
    base = pulse_total;
    tick();
    req_valid = 1'b0;
    chk("b2b_second_challenge", puf_challenge, 16'hC3C3);
    chk("b2b_second_busy", req_ready, 0);
    wait_rsp("b2b_second");
    tick();
    chk("b2b_final_idle", req_ready, 1);
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
